patram_arbiter: RTL and testbench

Shares the single synchronous read port of Pattern-RAM between the PPU tile and sprite fetchers (background, foreground, sprite_engine pattern_wrapper). Each requester sees a private request/grant/read-valid channel. The arbiter picks one request per cycle, drives the registered Pattern-RAM address, and tags the read so the returning 64-bit word is steered back to the owner. It sits in ppu_logic between the fetch engines and the Pattern-RAM port, replacing direct patram_addr connections.

---
 rtl/patram_arbiter.sv | 132 +++++++++++++
 tb/tb_patram_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/patram_arbiter.sv
// Pattern-RAM read-port arbiter: grants one fetcher per cycle, registers the RAM address and
// tags each read so the returning word is steered back to its owner.
// Build option: define PATRAM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority
// with the lowest index winning.
module patram_arbiter #(
   parameter int unsigned NUM_REQ    = 3,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*12-1:0] req_addr,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [11:0]           patram_addr,
   input  logic [63:0]           patram_rddata,
   output logic [NUM_REQ-1:0]    rd_valid,
   output logic [63:0]           rd_data,
   output logic                  busy
);

   localparam int unsigned IdW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   // Stage 0 lines up with patram_addr; the tail lines up with rddata.
   localparam int unsigned Depth = RD_LATENCY + 1;

   logic [NUM_REQ-1:0]          req_elig;
   logic                        grant_any;
   logic [IdW-1:0]              grant_id;
   logic [IdW-1:0]              cand;
   logic [11:0]                 addr_q, addr_d;
   logic [Depth-1:0]            vld_q, vld_d;
   logic [Depth-1:0][IdW-1:0]   id_q, id_d;

   // Reset gates the request so gnt drops as soon as rst_n falls, not at the next edge.
   assign req_elig = req & ~{NUM_REQ{flush}} & {NUM_REQ{rst_n}};

`ifdef PATRAM_ARB_RR_EN
   logic [IdW-1:0] ptr_q, ptr_d;

   // Round-robin search starting at the pointer.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = IdW'((32'(ptr_q) + k) % NUM_REQ);
         if (!grant_any && req_elig[cand]) begin
            grant_any = 1'b1;
            grant_id  = cand;
         end
      end
   end

   // Pointer moves past the winner; it holds when nothing is granted.
   always_comb begin
      ptr_d = ptr_q;
      if (grant_any) begin
         ptr_d = (grant_id == IdW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   // Fixed priority: lowest index wins.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = IdW'(k);
         if (!grant_any && req_elig[cand]) begin
            grant_any = 1'b1;
            grant_id  = cand;
         end
      end
   end
`endif

   // One-hot grant from the winning index.
   always_comb begin
      gnt = '0;
      if (grant_any) begin
         gnt[grant_id] = 1'b1;
      end
   end

   // Next address and tag pipeline; flush kills everything already in flight.
   always_comb begin
      vld_d    = '0;
      id_d     = id_q;
      vld_d[0] = grant_any;
      id_d[0]  = grant_id;
      for (int unsigned s = 1; s < Depth; s++) begin
         vld_d[s] = vld_q[s-1] & ~flush;
         id_d[s]  = id_q[s-1];
      end
      addr_d = grant_any ? req_addr[32'(grant_id)*12 +: 12] : addr_q;
   end

   // Address and tag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         vld_q  <= '0;
         id_q   <= '0;
      end else begin
         addr_q <= addr_d;
         vld_q  <= vld_d;
         id_q   <= id_d;
      end
   end

   // Steer the returning word to the owner recorded at the tail.
   always_comb begin
      rd_valid = '0;
      if (vld_q[Depth-1]) begin
         rd_valid[id_q[Depth-1]] = 1'b1;
      end
   end

   assign patram_addr = addr_q;
   assign rd_data     = patram_rddata;
   assign busy        = |vld_q;

endmodule

// File: tb/tb_patram_arbiter.sv
// Self-checking bench for patram_arbiter: table vectors, directed corner sequences and random
// traffic checked against a queue-based model of outstanding reads.
module tb_patram_arbiter;

   localparam int unsigned NReq  = 3;
   localparam int unsigned RdLat = 1;
`ifdef PATRAM_ARB_RR_EN
   localparam bit RrEn = 1'b1;
`else
   localparam bit RrEn = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic [2:0]  req;
   logic [35:0] req_addr;
   logic [2:0]  gnt;
   logic [11:0] patram_addr;
   logic [63:0] patram_rddata;
   logic [2:0]  rd_valid;
   logic [63:0] rd_data;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   patram_arbiter #(
      .NUM_REQ    (NReq),
      .RD_LATENCY (RdLat)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .req           (req),
      .req_addr      (req_addr),
      .gnt           (gnt),
      .patram_addr   (patram_addr),
      .patram_rddata (patram_rddata),
      .rd_valid      (rd_valid),
      .rd_data       (rd_data),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] data_fn(input logic [11:0] a);
      if (a == 12'h0A5) return 64'hDEAD_BEEF_0123_4567;
      return {4'hC, a, 4'h3, ~a, 4'h5, a ^ 12'h5A5, 4'h9, a + 12'd7};
   endfunction

   // Pattern-RAM model: samples the address each edge, data appears RdLat cycles later.
   logic [11:0] ram_pipe [RdLat];
   always @(posedge clk) begin
      ram_pipe[0] <= patram_addr;
      for (int i = 1; i < RdLat; i++) ram_pipe[i] <= ram_pipe[i-1];
   end
   assign patram_rddata = data_fn(ram_pipe[RdLat-1]);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: list of outstanding reads with their due cycle.
   typedef struct {
      int          due;
      int          id;
      logic [11:0] addr;
   } ret_t;

   ret_t        m_q[$];
   int          m_cyc = 0;
   int          m_ptr = 0;
   logic [11:0] m_addr = '0;
   logic [2:0]  m_rv;
   logic [2:0]  m_gnt;
   logic        m_busy;
   logic [63:0] m_data;
   bit          m_win;
   int          m_idx;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_q.delete();
         m_ptr  = 0;
         m_addr = '0;
         chk("rst_gnt", 64'(gnt), 64'd0);
         chk("rst_rd_valid", 64'(rd_valid), 64'd0);
         chk("rst_busy", 64'(busy), 64'd0);
         chk("rst_addr", 64'(patram_addr), 64'd0);
      end else begin
         m_rv   = '0;
         m_busy = 1'b0;
         m_data = '0;
         foreach (m_q[j]) begin
            if (m_q[j].due == m_cyc) begin
               m_rv[m_q[j].id] = 1'b1;
               m_data = data_fn(m_q[j].addr);
            end
            if (m_q[j].due - int'(RdLat) <= m_cyc && m_cyc <= m_q[j].due) m_busy = 1'b1;
         end
         chk("model_rd_valid", 64'(rd_valid), 64'(m_rv));
         chk("model_busy", 64'(busy), 64'(m_busy));
         chk("model_addr", 64'(patram_addr), 64'(m_addr));
         if (m_rv != 0) chk("model_rd_data", rd_data, m_data);
         m_win = 1'b0;
         m_idx = 0;
         m_gnt = '0;
         if (!flush) begin
            for (int k = 0; k < 3; k++) begin
               int c;
               c = RrEn ? (m_ptr + k) % 3 : k;
               if (!m_win && req[c]) begin
                  m_win = 1'b1;
                  m_idx = c;
               end
            end
         end
         if (m_win) m_gnt[m_idx] = 1'b1;
         chk("model_gnt", 64'(gnt), 64'(m_gnt));
         while (m_q.size() > 0 && m_q[0].due <= m_cyc) void'(m_q.pop_front());
         if (flush) m_q.delete();
         if (m_win) begin
            m_q.push_back('{due: m_cyc + 1 + int'(RdLat), id: m_idx,
                            addr: req_addr[m_idx*12 +: 12]});
            m_addr = req_addr[m_idx*12 +: 12];
            m_ptr  = (m_idx + 1) % 3;
         end
      end
      m_cyc++;
   end

   task automatic step(input logic [2:0] r, input logic f);
      @(posedge clk);
      #1;
      req   = r;
      flush = f;
   endtask

   task automatic do_reset();
      step(3'b000, 1'b0);
      rst_n = 1'b0;
      step(3'b000, 1'b0);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [2:0] req;
      logic       flush;
      logic [2:0] exp_fp;
      logic [2:0] exp_rr;
   } vec_t;

   vec_t tbl [10];

   initial begin
      tbl[0] = '{3'b000, 1'b0, 3'b000, 3'b000};
      tbl[1] = '{3'b111, 1'b0, 3'b001, 3'b001};
      tbl[2] = '{3'b111, 1'b1, 3'b000, 3'b000};
      tbl[3] = '{3'b110, 1'b0, 3'b010, 3'b010};
      tbl[4] = '{3'b101, 1'b0, 3'b001, 3'b100};
      tbl[5] = '{3'b100, 1'b0, 3'b100, 3'b100};
      tbl[6] = '{3'b011, 1'b0, 3'b001, 3'b001};
      tbl[7] = '{3'b001, 1'b0, 3'b001, 3'b001};
      tbl[8] = '{3'b111, 1'b0, 3'b001, 3'b010};
      tbl[9] = '{3'b011, 1'b0, 3'b001, 3'b001};

      rst_n    = 1'b0;
      req      = '0;
      flush    = 1'b0;
      req_addr = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("reset_gnt", 64'(gnt), 64'd0);
      chk("reset_rd_valid", 64'(rd_valid), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_addr", 64'(patram_addr), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Table vectors, pointer starts at 0.
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].req, tbl[i].flush);
         req_addr = {12'(12'h300 + i), 12'(12'h200 + i), 12'(12'h100 + i)};
         #2;
         chk("table_gnt", 64'(gnt), 64'(RrEn ? tbl[i].exp_rr : tbl[i].exp_fp));
      end
      repeat (RdLat + 2) step(3'b000, 1'b0);

      // Single read from the sprite fetcher.
      step(3'b100, 1'b0);
      req_addr = {12'h0A5, 24'h0};
      #2;
      chk("single_gnt", 64'(gnt), 64'b100);
      chk("single_busy_t", 64'(busy), 64'd0);
      step(3'b000, 1'b0);
      #2;
      chk("single_addr", 64'(patram_addr), 64'h0A5);
      chk("single_busy_t1", 64'(busy), 64'd1);
      chk("single_rv_t1", 64'(rd_valid), 64'd0);
      for (int k = 1; k <= RdLat; k++) begin
         step(3'b000, 1'b0);
         #2;
         chk("single_busy", 64'(busy), 64'd1);
         if (k == RdLat) begin
            chk("single_rd_valid", 64'(rd_valid), 64'b100);
            chk("single_rd_data", rd_data, 64'hDEAD_BEEF_0123_4567);
         end else begin
            chk("single_rv_early", 64'(rd_valid), 64'd0);
         end
      end
      step(3'b000, 1'b0);
      #2;
      chk("single_idle_busy", 64'(busy), 64'd0);
      chk("single_idle_rv", 64'(rd_valid), 64'd0);

      // Three-way contention right after reset.
      do_reset();
      for (int k = 0; k < 6; k++) begin
         step(3'b111, 1'b0);
         req_addr = 36'({$urandom, $urandom});
         #2;
         chk("contention_gnt", 64'(gnt), RrEn ? 64'(1 << (k % 3)) : 64'd1);
      end
      repeat (RdLat + 2) step(3'b000, 1'b0);

      // Back-to-back reads from the foreground fetcher.
      for (int c = 0; c < 5 + RdLat; c++) begin
         if (c < 3) begin
            step(3'b010, 1'b0);
            req_addr = {12'h0, 12'(12'h010 + c), 12'h0};
         end else begin
            step(3'b000, 1'b0);
         end
         #2;
         chk("b2b_gnt", 64'(gnt), (c < 3) ? 64'b010 : 64'd0);
         if (c >= 1 + RdLat && c < 4 + RdLat) begin
            chk("b2b_rd_valid", 64'(rd_valid), 64'b010);
            chk("b2b_rd_data", rd_data, data_fn(12'(12'h010 + c - 1 - RdLat)));
         end else begin
            chk("b2b_rv_gap", 64'(rd_valid), 64'd0);
         end
      end

      // Flush while a read is in flight.
      step(3'b001, 1'b0);
      req_addr = {24'h0, 12'h100};
      #2;
      chk("flush_gnt_t", 64'(gnt), 64'b001);
      step(3'b001, 1'b1);
      req_addr = {24'h0, 12'h101};
      #2;
      chk("flush_gnt_f", 64'(gnt), 64'd0);
      chk("flush_rv_f", 64'(rd_valid), 64'd0);
      step(3'b010, 1'b0);
      req_addr = {12'h0, 12'h200, 12'h0};
      #2;
      chk("flush_gnt_after", 64'(gnt), 64'b010);
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_rv_after", 64'(rd_valid), 64'd0);
      for (int k = 1; k <= RdLat + 1; k++) begin
         step(3'b000, 1'b0);
         #2;
         chk("flush_rd_valid", 64'(rd_valid), (k == RdLat + 1) ? 64'b010 : 64'd0);
      end
      step(3'b000, 1'b0);

      // Asynchronous reset with reads in flight.
      step(3'b001, 1'b0);
      req_addr = {24'h0, 12'h1A1};
      step(3'b010, 1'b0);
      req_addr = {12'h0, 12'h2B2, 12'h0};
      step(3'b111, 1'b0);
      #2;
      chk("arst_busy_before", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_gnt", 64'(gnt), 64'd0);
      chk("arst_rd_valid", 64'(rd_valid), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_addr", 64'(patram_addr), 64'd0);
      step(3'b110, 1'b0);
      rst_n = 1'b1;
      req_addr = {12'h3C3, 12'h2C2, 12'h1C1};
      #2;
      chk("arst_first_gnt", 64'(gnt), 64'b010);
      for (int k = 1; k <= RdLat + 1; k++) begin
         step(3'b000, 1'b0);
         #2;
         chk("arst_rd_valid_after", 64'(rd_valid), (k == RdLat + 1) ? 64'b010 : 64'd0);
      end

      // Random traffic against the model.
      for (int n = 0; n < 500; n++) begin
         step(3'($urandom), ($urandom_range(0, 15) == 0));
         req_addr = 36'({$urandom, $urandom});
      end
      repeat (RdLat + 3) step(3'b000, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
